// File: rtl/pong_pkg.sv
// Shared Pong definitions: miss-detector state encoding, winner codes, default widths
// and screen geometry.
package pong_pkg;

    localparam int DEF_X_W        = 10;
    localparam int DEF_Y_W        = 10;
    localparam int DEF_SCORE_W    = 5;
    localparam int DEF_LEFT_X     = 16;
    localparam int DEF_RIGHT_X    = 623;
    localparam int DEF_PADDLE_H   = 64;
    localparam int DEF_HOLDOFF_FR = 60;
    localparam int DEF_SCORE_MIN  = 0;
    localparam int DEF_SCORE_MAX  = 20;

    typedef enum logic [1:0] {
        ARMED     = 2'd0,
        HOLDOFF   = 2'd1,
        GAME_OVER = 2'd2
    } md_state_t;

    typedef logic [1:0] winner_t;

    localparam winner_t WIN_NONE = 2'b00;
    localparam winner_t WIN_P1   = 2'b01;
    localparam winner_t WIN_P2   = 2'b10;

    // Bits needed to hold the values 0..n.
    function automatic int cnt_w(input int n);
        return (n < 2) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/miss_detector_if.sv
// Position/score inputs and miss/hit/game-end outputs of the miss detector.
// master = motion/score side driving positions, slave = the detector.
interface miss_detector_if
    import pong_pkg::*;
#(
    parameter int X_W     = DEF_X_W,
    parameter int Y_W     = DEF_Y_W,
    parameter int SCORE_W = DEF_SCORE_W
);
    logic               frame_tick;
    logic [X_W-1:0]     ball_x;
    logic [Y_W-1:0]     ball_y;
    logic [Y_W-1:0]     p1_y;
    logic [Y_W-1:0]     p2_y;
    logic [SCORE_W-1:0] score;
    logic               restart;
    logic               p1miss;
    logic               p2miss;
    logic               p1hit;
    logic               p2hit;
    logic               game_over;
    logic [1:0]         winner;

    modport master (
        output frame_tick, ball_x, ball_y, p1_y, p2_y, score, restart,
        input  p1miss, p2miss, p1hit, p2hit, game_over, winner
    );

    modport slave (
        input  frame_tick, ball_x, ball_y, p1_y, p2_y, score, restart,
        output p1miss, p2miss, p1hit, p2hit, game_over, winner
    );

endinterface

// File: rtl/miss_detector_holdoff_counter.sv
// Loadable frame down-counter used to ignore the goal lines for a while after a miss,
// reset or restart. Saturates at zero; zero flag drives re-arming.
module holdoff_counter
    import pong_pkg::*;
#(
    parameter int LOAD_VAL = DEF_HOLDOFF_FR,
    parameter int W        = cnt_w(LOAD_VAL)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic en,
    output logic zero
);

    logic [W-1:0] count_p1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_p1 <= W'(LOAD_VAL);
        end else if (load) begin
            count_p1 <= W'(LOAD_VAL);
        end else if (en && (count_p1 != '0)) begin
            count_p1 <= count_p1 - 1'b1;
        end
    end

    assign zero = (count_p1 == '0);

endmodule

// File: rtl/miss_detector.sv
// Watches ball/paddle positions each frame, issues registered one-cycle miss/hit pulses,
// and stops play when the score keeper reports a winning score.
module miss_detector
    import pong_pkg::*;
#(
    parameter int X_W        = DEF_X_W,
    parameter int Y_W        = DEF_Y_W,
    parameter int SCORE_W    = DEF_SCORE_W,
    parameter int LEFT_X     = DEF_LEFT_X,
    parameter int RIGHT_X    = DEF_RIGHT_X,
    parameter int PADDLE_H   = DEF_PADDLE_H,
    parameter int HOLDOFF_FR = DEF_HOLDOFF_FR,
    parameter int SCORE_MIN  = DEF_SCORE_MIN,
    parameter int SCORE_MAX  = DEF_SCORE_MAX
) (
    input logic            clk,
    input logic            rst_n,
    miss_detector_if.slave bus
);

    md_state_t state_p1, state_nxt;
    winner_t   winner_p1, winner_nxt;
    logic      p1miss_p1, p2miss_p1, p1hit_p1, p2hit_p1, game_over_p1;
    logic      p1miss_nxt, p2miss_nxt, p1hit_nxt, p2hit_nxt;
    logic      cnt_load, cnt_en, cnt_zero;

    // Paddle bottom edge is one bit wider so a paddle near the screen bottom cannot wrap.
    logic [Y_W:0] p1_end, p2_end;
    logic         in_span1, in_span2, at_left, at_right, in_field, score_lo, score_hi;

    assign p1_end   = {1'b0, bus.p1_y} + (Y_W+1)'(PADDLE_H);
    assign p2_end   = {1'b0, bus.p2_y} + (Y_W+1)'(PADDLE_H);
    assign in_span1 = (bus.ball_y >= bus.p1_y) && ({1'b0, bus.ball_y} < p1_end);
    assign in_span2 = (bus.ball_y >= bus.p2_y) && ({1'b0, bus.ball_y} < p2_end);
    assign at_left  = (bus.ball_x <= X_W'(LEFT_X));
    assign at_right = (bus.ball_x >= X_W'(RIGHT_X));
    assign in_field = !at_left && !at_right;
    assign score_lo = (bus.score <= SCORE_W'(SCORE_MIN));
    assign score_hi = (bus.score >= SCORE_W'(SCORE_MAX));

    holdoff_counter #(
        .LOAD_VAL (HOLDOFF_FR)
    ) u_holdoff (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (cnt_load),
        .en    (cnt_en),
        .zero  (cnt_zero)
    );

    always_comb begin
        state_nxt  = state_p1;
        winner_nxt = winner_p1;
        p1miss_nxt = 1'b0;
        p2miss_nxt = 1'b0;
        p1hit_nxt  = 1'b0;
        p2hit_nxt  = 1'b0;
        cnt_load   = 1'b0;
        cnt_en     = 1'b0;
        case (state_p1)
            ARMED, HOLDOFF: begin
                // A winning score overrides anything seen at the goal lines this cycle.
                if (score_lo || score_hi) begin
                    state_nxt  = GAME_OVER;
                    winner_nxt = score_lo ? WIN_P1 : WIN_P2;
                end else if (bus.frame_tick && (state_p1 == ARMED)) begin
                    if (at_left) begin
                        if (in_span1) begin
                            p1hit_nxt = 1'b1;
                        end else begin
                            p1miss_nxt = 1'b1;
                            state_nxt  = HOLDOFF;
                            cnt_load   = 1'b1;
                        end
                    end else if (at_right) begin
                        if (in_span2) begin
                            p2hit_nxt = 1'b1;
                        end else begin
                            p2miss_nxt = 1'b1;
                            state_nxt  = HOLDOFF;
                            cnt_load   = 1'b1;
                        end
                    end
                end else if (bus.frame_tick) begin
                    cnt_en = 1'b1;
                    if (cnt_zero && in_field) begin
                        state_nxt = ARMED;
                    end
                end
            end
            GAME_OVER: begin
                if (bus.restart) begin
                    state_nxt  = HOLDOFF;
                    winner_nxt = WIN_NONE;
                    cnt_load   = 1'b1;
                end
            end
            default: begin
                state_nxt = HOLDOFF;
                cnt_load  = 1'b1;
            end
        endcase
    end

    // Registered outputs: pulses appear the cycle after the frame tick that caused them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_p1     <= HOLDOFF;
            winner_p1    <= WIN_NONE;
            game_over_p1 <= 1'b0;
            p1miss_p1    <= 1'b0;
            p2miss_p1    <= 1'b0;
            p1hit_p1     <= 1'b0;
            p2hit_p1     <= 1'b0;
        end else begin
            state_p1     <= state_nxt;
            winner_p1    <= winner_nxt;
            game_over_p1 <= (state_nxt == GAME_OVER);
            p1miss_p1    <= p1miss_nxt;
            p2miss_p1    <= p2miss_nxt;
            p1hit_p1     <= p1hit_nxt;
            p2hit_p1     <= p2hit_nxt;
        end
    end

    assign bus.p1miss    = p1miss_p1;
    assign bus.p2miss    = p2miss_p1;
    assign bus.p1hit     = p1hit_p1;
    assign bus.p2hit     = p2hit_p1;
    assign bus.game_over = game_over_p1;
    assign bus.winner    = winner_p1;

endmodule

// File: tb/tb_miss_detector.sv
// Scoreboard bench for miss_detector: directed scenarios then randomized play against
// a frame-level behavioural model of the game rules.
module tb_miss_detector;
    import pong_pkg::*;

    localparam int LX   = 16;
    localparam int RX   = 623;
    localparam int PH   = 64;
    localparam int HOLD = 60;
    localparam int SMIN = 0;
    localparam int SMAX = 20;

    localparam int K_P1MISS = 1;
    localparam int K_P2MISS = 2;
    localparam int K_P1HIT  = 3;
    localparam int K_P2HIT  = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    miss_detector_if bus ();

    miss_detector dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        int kind;
        int cyc;
    } ev_t;

    ev_t expq[$];
    int  n_tests = 0;
    int  n_fail  = 0;
    int  cyc     = 0;

    // Model: mode 0 = playing, 1 = waiting after miss/reset, 2 = match over.
    int  m_mode   = 1;
    int  m_frames = HOLD;
    int  m_win    = 0;
    int  exp_go   = 0;
    int  exp_win  = 0;

    int  cur_by = 300, cur_p1 = 100, cur_p2 = 100, cur_sc = 10;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_ev(input int k, input int c);
        ev_t e;
        e.kind = k;
        e.cyc  = c;
        expq.push_back(e);
    endtask

    task automatic model(input bit ft, input int bx, input int by, input int p1,
                         input int p2, input int sc, input bit rs);
        int up;
        up = cyc + 1;
        if (m_mode != 2 && (sc <= SMIN || sc >= SMAX)) begin
            m_mode = 2;
            m_win  = (sc <= SMIN) ? 1 : 2;
        end else if (m_mode == 2) begin
            if (rs) begin
                m_mode   = 1;
                m_frames = HOLD;
                m_win    = 0;
            end
        end else if (ft && m_mode == 1) begin
            if (m_frames == 0 && bx > LX && bx < RX) m_mode = 0;
            else if (m_frames > 0) m_frames--;
        end else if (ft && m_mode == 0) begin
            if (bx <= LX) begin
                if (by >= p1 && by < p1 + PH) push_ev(K_P1HIT, up);
                else begin
                    push_ev(K_P1MISS, up);
                    m_mode   = 1;
                    m_frames = HOLD;
                end
            end else if (bx >= RX) begin
                if (by >= p2 && by < p2 + PH) push_ev(K_P2HIT, up);
                else begin
                    push_ev(K_P2MISS, up);
                    m_mode   = 1;
                    m_frames = HOLD;
                end
            end
        end
        exp_go  = (m_mode == 2) ? 1 : 0;
        exp_win = m_win;
    endtask

    task automatic drive(input bit ft, input int bx, input int by, input int p1,
                         input int p2, input int sc, input bit rs);
        @(negedge clk);
        bus.frame_tick = ft;
        bus.ball_x     = 10'(bx);
        bus.ball_y     = 10'(by);
        bus.p1_y       = 10'(p1);
        bus.p2_y       = 10'(p2);
        bus.score      = 5'(sc);
        bus.restart    = rs;
        model(ft, bx, by, p1, p2, sc, rs);
    endtask

    task automatic tick(input int bx);
        drive(1'b1, bx, cur_by, cur_p1, cur_p2, cur_sc, 1'b0);
        drive(1'b0, bx, cur_by, cur_p1, cur_p2, cur_sc, 1'b0);
    endtask

    task automatic rearm();
        repeat (HOLD + 1) tick(320);
    endtask

    // Monitor: compares status every cycle and matches each pulse to the scoreboard.
    always begin
        @(posedge clk);
        #1;
        if (rst_n) begin
            int  npulse;
            int  k;
            ev_t e;
            check("game_over", int'(bus.game_over), exp_go);
            check("winner", int'(bus.winner), exp_win);
            while (expq.size() > 0 && expq[0].cyc < cyc) begin
                e = expq.pop_front();
                check("missing_pulse", 0, e.kind);
            end
            npulse = int'(bus.p1miss) + int'(bus.p2miss) + int'(bus.p1hit) + int'(bus.p2hit);
            if (npulse > 1) begin
                check("pulse_count", npulse, 1);
            end else if (npulse == 1) begin
                k = bus.p1miss ? K_P1MISS : bus.p2miss ? K_P2MISS : bus.p1hit ? K_P1HIT : K_P2HIT;
                if (expq.size() == 0) begin
                    check("unexpected_pulse", k, 0);
                end else begin
                    e = expq.pop_front();
                    check("pulse_kind", k, e.kind);
                    check("pulse_cycle", cyc, e.cyc);
                end
            end
        end
    end

    initial begin
        ev_t e;
        bus.frame_tick = 1'b0;
        bus.ball_x     = 10'd5;
        bus.ball_y     = 10'd300;
        bus.p1_y       = 10'd100;
        bus.p2_y       = 10'd100;
        bus.score      = 5'd10;
        bus.restart    = 1'b0;

        #12;
        check("rst_p1miss", int'(bus.p1miss), 0);
        check("rst_p2miss", int'(bus.p2miss), 0);
        check("rst_p1hit", int'(bus.p1hit), 0);
        check("rst_p2hit", int'(bus.p2hit), 0);
        check("rst_game_over", int'(bus.game_over), 0);
        check("rst_winner", int'(bus.winner), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Ball parked on the left line from reset: holdoff suppresses it, then one miss.
        cur_by = 300; cur_p1 = 100;
        repeat (HOLD) tick(5);
        tick(320);
        tick(5);

        // Paddle span edges.
        rearm();
        cur_by = 100; tick(5);
        cur_by = 163; tick(5);
        cur_by = 164; tick(5);

        // Paddle near the bottom must not wrap.
        rearm();
        cur_p2 = 1000; cur_by = 1020; tick(630);

        // Ball held on the goal line after a miss yields exactly one pulse.
        cur_by = 300; tick(5);
        repeat (200) tick(5);
        tick(320);
        tick(5);

        // Winning score with a miss on the same tick.
        rearm();
        cur_sc = 20; tick(5);
        repeat (5) tick(5);
        cur_sc = 10;
        drive(1'b0, 320, cur_by, cur_p1, cur_p2, cur_sc, 1'b1);
        repeat (HOLD) tick(320);
        tick(5);
        tick(320);
        tick(5);

        // Player 1 wins at the low score, then restart.
        rearm();
        cur_sc = 0;
        drive(1'b0, 320, cur_by, cur_p1, cur_p2, cur_sc, 1'b0);
        repeat (3) tick(320);
        cur_sc = 10;
        drive(1'b0, 320, cur_by, cur_p1, cur_p2, cur_sc, 1'b1);

        // Asynchronous reset while p2miss is high.
        rearm();
        cur_p2 = 500; cur_by = 0;
        drive(1'b1, 630, cur_by, cur_p1, cur_p2, cur_sc, 1'b0);
        @(posedge clk);
        #2;
        check("p2miss_before_reset", int'(bus.p2miss), 1);
        #1;
        rst_n = 1'b0;
        #1;
        check("p2miss_async_clear", int'(bus.p2miss), 0);
        check("game_over_async_clear", int'(bus.game_over), 0);
        bus.frame_tick = 1'b0;
        m_mode = 1; m_frames = HOLD; m_win = 0; exp_go = 0; exp_win = 0;
        @(negedge clk);
        rst_n = 1'b1;
        cur_by = 300;
        repeat (HOLD) tick(320);
        tick(5);
        tick(320);
        tick(5);

        // Randomized play, including back-to-back frame ticks and stray restarts.
        for (int i = 0; i < 3000; i++) begin
            int r, bx, by, p1, p2, sc, s;
            bit ft, rs;
            ft = ($urandom_range(0, 1) == 1);
            r  = int'($urandom_range(0, 9));
            bx = (r < 4) ? int'($urandom_range(0, 16)) :
                 (r < 6) ? int'($urandom_range(623, 1023)) : int'($urandom_range(17, 622));
            p1 = int'($urandom_range(0, 1023));
            p2 = int'($urandom_range(0, 1023));
            if ($urandom_range(0, 1) == 1) begin
                by = ((bx <= LX) ? p1 : p2) + int'($urandom_range(0, 80)) - 8;
                if (by < 0) by = 0;
                if (by > 1023) by = 1023;
            end else begin
                by = int'($urandom_range(0, 1023));
            end
            s  = int'($urandom_range(0, 199));
            sc = (s == 0) ? 0 : (s == 1) ? 20 : (s < 5) ? int'($urandom_range(1, 19)) : 10;
            rs = ($urandom_range(0, 29) == 0);
            drive(ft, bx, by, p1, p2, sc, rs);
        end

        cur_sc = 10;
        repeat (3) drive(1'b0, 320, 0, 0, 0, 10, 1'b0);
        while (expq.size() > 0) begin
            e = expq.pop_front();
            check("missing_pulse_end", 0, e.kind);
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
